decode_issue: RTL
=================

Name: decode_issue

Overview:
- Decode/issue stage feeding the execute-stage ALU: the producer end of the ALU's opcode/funct/operand interface.
- Accepts fetched 32-bit instructions over a valid/ready handshake, splits them into fields and reads operands from an internal register file.
- Builds immediates and holds a registered issue slot for the ALU.
- A per-register scoreboard stalls issue until pending writebacks land.

Parameters:
- WD_SIZE, 32, datapath/register width
- NUM_REGS, 32, architectural registers (x0 hardwired zero)
- REG_ADDR_BITS, 5, log2(NUM_REGS)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- fe_valid  in  1  fetch presents instruction
- fe_ready  out  1  stage accepts instruction this cycle
- fe_instr  in  32  instruction word
- fe_pc  in  WD_SIZE  instruction address
- ex_valid  out  1  issue slot holds instruction
- ex_ready  in  1  execute consumes slot this cycle
- ex_opcode  out  OPCODE_BITS  to ALU opcode
- ex_funct7  out  FUNCT7_BITS  to ALU funct7
- ex_funct3  out  FUNCT3_BITS  to ALU funct3
- ex_op1_data  out  WD_SIZE  to ALU op1
- ex_op2_data  out  WD_SIZE  to ALU op2
- ex_rs2_data  out  WD_SIZE  store data / branch compare operand
- ex_rd  out  REG_ADDR_BITS  destination register
- ex_rd_we  out  1  instruction writes rd
- wb_valid  in  1  writeback this cycle
- wb_rd  in  REG_ADDR_BITS  writeback register
- wb_data  in  WD_SIZE  writeback value
- illegal_instr  out  1  one-cycle pulse, unknown opcode dropped

Behaviour:
- Reset (async, reset_n=0):
  - ex_valid=0, all ex_* data outputs 0, illegal_instr=0.
  - All scoreboard bits 0, all registers 0.
- Field split: opcode=instr[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
- Operand mapping (the ALU computes op2-op1 for SUBS):
  - OPCODE_OP: op1=R[rs2], op2=R[rs1], so SUBS yields rs1-rs2; rd_we=1.
  - OPCODE_LD: op1=R[rs1], op2=sext(I-imm instr[31:20]); rd_we=1.
  - OPCODE_ST: op1=R[rs1], op2=sext(S-imm {[31:25],[11:7]}); rs2_data=R[rs2]; rd_we=0.
  - OPCODE_BR: op1=fe_pc, op2=sext(B-imm, bit0=0); rs2_data=R[rs2], op2 holds the target offset only, op1 carries pc; rd_we=0.
  - OPCODE_JM: op1=fe_pc, op2=sext(J-imm, bit0=0); rd_we=1.
  - Other opcodes: instruction consumed (fe_ready honoured), not issued; illegal_instr=1 next cycle for one cycle.
  - rd==0 forces rd_we=0. Reads of x0 return 0.
- Hazard: stall when a used source (rs1 and/or rs2 per format) or rd (if rd_we) has its scoreboard bit set.
- Handshake:
  - slot_free = !ex_valid || ex_ready.
  - fe_ready = slot_free && !hazard; combinational, no dependence on fe_valid.
  - Accept on fe_valid && fe_ready. The slot loads at the next edge (latency 1); ex_valid is set unless the instruction is illegal.
  - ex_valid && ex_ready with no accept: ex_valid clears.
  - ex_* fields hold stable while ex_valid && !ex_ready.
- Scoreboard:
  - Set bit[rd] on accept with rd_we.
  - Clear bit[wb_rd] on wb_valid.
  - Same rd set and cleared in the same cycle: set wins.
  - wb_valid with rd 0 is ignored.
- Register file: written at the clock edge on wb_valid when wb_rd≠0.
- Reset mid-operation: slot and scoreboard are discarded immediately.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined:
  - Operand reads matching wb_rd in a wb_valid cycle take wb_data.
  - The scoreboard bit being cleared that cycle does not stall.
- Undefined:
  - The hazard uses the current scoreboard bit, so the consumer stalls through the wb cycle and issues the cycle after, reading the written register.

Decomposition:
- Shared package holds:
  - OPCODE_BITS, FUNCT7_BITS, FUNCT3_BITS, WD_SIZE.
  - OPCODE_OP/LD/ST/JM/BR and SUBS.
  - A decoded-instruction struct typedef (fields, imm, rd_we).
  - An immediate-format enum.
- Sub-module reg_file, instantiated inside this block:
  - Two combinational read ports, one write port, x0 zero.
  - Async reset clears all registers.

Test Plan:
- Reset then OP SUBS (rs1=x1=9 preloaded via wb, rs2=x2=4) → next cycle ex_valid=1, op1=4, op2=9, ex_rd_we=1.
- LD x3 with imm=-8, rs1=x1 holding 0x100 → op1=0x100, op2=0xFFFFFFF8, ex_rd=3.
- Back-to-back ADD x5 then ADD using x5, no wb → fe_ready=0 until wb_valid, wb_rd=5, wb_data=7.
  - With the bypass macro: second instruction issues in the wb cycle with op1/op2=7.
  - Without it: second instruction issues one cycle later.
- ex_ready=0 for 3 cycles while the slot is full → ex_* stable, fe_ready=0; ex_ready=1 → the next instruction is accepted the same cycle.
- Opcode 0x7F → not issued, illegal_instr high exactly one cycle, ex_valid stays 0.
- reset_n low while ex_valid=1 and x7 pending → ex_valid=0 and scoreboard clear asynchronously; a following instruction using x7 issues without stall.

Source files
------------

// File: rtl/decode_issue_pkg.sv
// Shared types and decode helper for the decode/issue stage.
// Optional feature macro: DECODE_WB_BYPASS_EN (consumed in decode_issue.sv).
package decode_issue_pkg;

  localparam int WD_SIZE     = 32;
  localparam int OPCODE_BITS = 7;
  localparam int FUNCT7_BITS = 7;
  localparam int FUNCT3_BITS = 3;

  localparam logic [OPCODE_BITS-1:0] OPCODE_OP = 7'b0110011;
  localparam logic [OPCODE_BITS-1:0] OPCODE_LD = 7'b0000011;
  localparam logic [OPCODE_BITS-1:0] OPCODE_ST = 7'b0100011;
  localparam logic [OPCODE_BITS-1:0] OPCODE_BR = 7'b1100011;
  localparam logic [OPCODE_BITS-1:0] OPCODE_JM = 7'b1101111;

  localparam logic [FUNCT7_BITS-1:0] SUBS = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_fmt_t;

  typedef struct packed {
    logic [OPCODE_BITS-1:0] opcode;
    logic [FUNCT7_BITS-1:0] funct7;
    logic [FUNCT3_BITS-1:0] funct3;
    logic [4:0]             rd;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [WD_SIZE-1:0]     imm;
    imm_fmt_t               imm_fmt;
    logic                   rd_we;
    logic                   use_rs1;
    logic                   use_rs2;
    logic                   legal;
  } decoded_t;

  function automatic decoded_t decode_instr(input logic [31:0] instr);
    decoded_t d;
    d.opcode  = instr[6:0];
    d.rd      = instr[11:7];
    d.funct3  = instr[14:12];
    d.rs1     = instr[19:15];
    d.rs2     = instr[24:20];
    d.funct7  = instr[31:25];
    d.imm     = '0;
    d.imm_fmt = IMM_NONE;
    d.rd_we   = 1'b0;
    d.use_rs1 = 1'b0;
    d.use_rs2 = 1'b0;
    d.legal   = 1'b1;
    case (d.opcode)
      OPCODE_OP: begin
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
        d.rd_we   = 1'b1;
      end
      OPCODE_LD: begin
        d.imm_fmt = IMM_I;
        d.imm     = {{20{instr[31]}}, instr[31:20]};
        d.use_rs1 = 1'b1;
        d.rd_we   = 1'b1;
      end
      OPCODE_ST: begin
        d.imm_fmt = IMM_S;
        d.imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
      end
      OPCODE_BR: begin
        d.imm_fmt = IMM_B;
        d.imm     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
      end
      OPCODE_JM: begin
        d.imm_fmt = IMM_J;
        d.imm     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        d.rd_we   = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    if (d.rd == 5'd0) d.rd_we = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_reg_file.sv
// Architectural register file: two combinational read ports, one write port, x0 reads zero.
module decode_issue_reg_file
  import decode_issue_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_BITS-1:0] rd_addr_a,
  output logic [DATA_W-1:0]    rd_data_a,
  input  logic [ADDR_BITS-1:0] rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_b,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: splits instructions, reads operands, scoreboards pending writebacks
// and holds a registered ALU issue slot. Optional macro DECODE_WB_BYPASS_EN forwards wb_data.
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int WD_SIZE       = 32,
  parameter int NUM_REGS      = 32,
  parameter int REG_ADDR_BITS = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fe_valid,
  output logic                     fe_ready,
  input  logic [31:0]              fe_instr,
  input  logic [WD_SIZE-1:0]       fe_pc,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [OPCODE_BITS-1:0]   ex_opcode,
  output logic [FUNCT7_BITS-1:0]   ex_funct7,
  output logic [FUNCT3_BITS-1:0]   ex_funct3,
  output logic [WD_SIZE-1:0]       ex_op1_data,
  output logic [WD_SIZE-1:0]       ex_op2_data,
  output logic [WD_SIZE-1:0]       ex_rs2_data,
  output logic [REG_ADDR_BITS-1:0] ex_rd,
  output logic                     ex_rd_we,
  input  logic                     wb_valid,
  input  logic [REG_ADDR_BITS-1:0] wb_rd,
  input  logic [WD_SIZE-1:0]       wb_data,
  output logic                     illegal_instr
);

  decoded_t            dec;
  logic [WD_SIZE-1:0]  rf_rs1, rf_rs2, rs1_val, rs2_val;
  logic [NUM_REGS-1:0] sb, sb_set, sb_clr, sb_eff;
  logic [WD_SIZE-1:0]  op1_nxt, op2_nxt, rs2d_nxt;
  logic                hazard, slot_free, accept;

  assign dec = decode_instr(fe_instr);

  decode_issue_reg_file #(
    .DATA_W   (WD_SIZE),
    .NUM_REGS (NUM_REGS),
    .ADDR_BITS(REG_ADDR_BITS)
  ) u_reg_file (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_addr_a(dec.rs1),
    .rd_data_a(rf_rs1),
    .rd_addr_b(dec.rs2),
    .rd_data_b(rf_rs2),
    .we       (wb_valid),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data)
  );

  always_comb begin
    sb_clr = '0;
    if (wb_valid && wb_rd != '0) sb_clr[wb_rd] = 1'b1;
    sb_set = '0;
    if (accept && dec.rd_we) sb_set[dec.rd] = 1'b1;
  end

`ifdef DECODE_WB_BYPASS_EN
  // A writeback landing this cycle satisfies the consumer directly.
  assign rs1_val = (wb_valid && wb_rd == dec.rs1 && dec.rs1 != '0) ? wb_data : rf_rs1;
  assign rs2_val = (wb_valid && wb_rd == dec.rs2 && dec.rs2 != '0) ? wb_data : rf_rs2;
  assign sb_eff  = sb & ~sb_clr;
`else
  assign rs1_val = rf_rs1;
  assign rs2_val = rf_rs2;
  assign sb_eff  = sb;
`endif

  assign hazard = (dec.use_rs1 && sb_eff[dec.rs1]) ||
                  (dec.use_rs2 && sb_eff[dec.rs2]) ||
                  (dec.rd_we   && sb_eff[dec.rd]);

  assign slot_free = !ex_valid || ex_ready;
  assign fe_ready  = slot_free && !hazard;
  assign accept    = fe_valid && fe_ready;

  // The ALU computes op2-op1, so register-register ops swap sources.
  always_comb begin
    op1_nxt  = '0;
    op2_nxt  = '0;
    rs2d_nxt = '0;
    case (dec.imm_fmt)
      IMM_NONE: begin
        op1_nxt = rs2_val;
        op2_nxt = rs1_val;
      end
      IMM_I: begin
        op1_nxt = rs1_val;
        op2_nxt = dec.imm;
      end
      IMM_S: begin
        op1_nxt  = rs1_val;
        op2_nxt  = dec.imm;
        rs2d_nxt = rs2_val;
      end
      IMM_B: begin
        op1_nxt  = fe_pc;
        op2_nxt  = dec.imm;
        rs2d_nxt = rs2_val;
      end
      IMM_J: begin
        op1_nxt = fe_pc;
        op2_nxt = dec.imm;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid      <= 1'b0;
      ex_opcode     <= '0;
      ex_funct7     <= '0;
      ex_funct3     <= '0;
      ex_op1_data   <= '0;
      ex_op2_data   <= '0;
      ex_rs2_data   <= '0;
      ex_rd         <= '0;
      ex_rd_we      <= 1'b0;
      illegal_instr <= 1'b0;
      sb            <= '0;
    end else begin
      sb            <= (sb & ~sb_clr) | sb_set;
      illegal_instr <= accept && !dec.legal;
      if (accept) begin
        ex_valid <= dec.legal;
        if (dec.legal) begin
          ex_opcode   <= dec.opcode;
          ex_funct7   <= dec.funct7;
          ex_funct3   <= dec.funct3;
          ex_op1_data <= op1_nxt;
          ex_op2_data <= op2_nxt;
          ex_rs2_data <= rs2d_nxt;
          ex_rd       <= dec.rd;
          ex_rd_we    <= dec.rd_we;
        end
      end else if (ex_valid && ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule
